hash_match_bank: RTL and testbench
==================================

# hash_match_bank

Parametrised, pipelined successor to the combinational 64-entry target-hash comparator. It holds a loadable bank of DEPTH target NTLM hashes. Candidate hashes arrive from the MD4 core over a valid/ready stream, and the block returns the lowest matching entry index through a back-pressurable result stream. It also tracks which targets have been cracked, so solved entries can be excluded from later comparisons, and reports when every loaded target is solved.

## Interface
Parameters:
- HASH_W, 128, hash width in bits
- DEPTH, 64, number of target entries (≥2)
- IDX_W, $clog2(DEPTH), entry index width
- TAG_W, 32, candidate tag width (password counter / ID) carried alongside the hash
- CNT_W, $clog2(DEPTH+1), found-counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- load_en  in  1  write load_hash into entry load_idx this cycle
- load_idx  in  IDX_W  entry to write; values ≥ DEPTH are ignored
- load_hash  in  HASH_W  target hash to store
- clear_all  in  1  invalidate all entries and clear all found state
- mask_found  in  1  1 = entries already found are excluded from comparison
- cand_valid  in  1  candidate present
- cand_ready  out  1  block accepts the candidate this cycle
- cand_hash  in  HASH_W  candidate hash
- cand_tag  in  TAG_W  candidate tag
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts the result
- res_hit  out  1  1 = candidate matched an eligible entry
- res_idx  out  IDX_W  lowest matching index; 0 on miss
- res_tag  out  TAG_W  tag of the candidate that produced this result
- found_count  out  CNT_W  number of entries with found bit set
- all_found  out  1  at least one entry valid and every valid entry found

## Operation
- Storage: per entry, hash[HASH_W], valid bit, found bit.
- load_en with a legal index writes the hash, sets valid=1 and clears found for that entry. If found was 1, found_count decrements.
- clear_all clears every valid and found bit and sets found_count=0. It takes priority over load_en and over a same-cycle hit update. It does not flush in-flight candidates; they are compared against the cleared bank and miss.
- Eligibility: entry i is eligible when valid[i] && !(mask_found && found[i]). mask_found and bank state are sampled in the cycle the compare is evaluated (stage 1 → output transfer).
- Compare: all eligible entries are compared against the stage-1 hash in parallel. A fixed-priority encoder selects the lowest index. No eligible match gives res_hit=0 and res_idx=0.
- Found update on hit: found[res_idx] is set in the same edge as the result register loads.
  - found_count increments only if that found bit was 0.
  - If a load to the same index occurs in that edge, the load wins: found=0, no increment.
- all_found is combinational from the registered bits: (|valid) && ((valid & ~found) == 0).

## Timing
- Pipeline: stage 1 (s1_valid, s1_hash, s1_tag), then output register (res_*).
- advance = !res_valid || res_ready.
- cand_ready = !s1_valid || advance, combinational. It never depends on cand_valid.
- Candidate accepted at edge k appears at res_valid after edge k+1, i.e. 2-cycle latency.
- Full throughput is 1 candidate per cycle while res_ready=1.
- Stall behaviour:
  - While res_valid && !res_ready, all res_* outputs hold stable.
  - stage 1 holds.
  - cand_ready=0 if s1 is full.
- Stage 1 moves to output only when s1_valid && advance. When advance && !s1_valid, res_valid drops to 0.
- Reset (n_rst=0, async), all forced to 0:
  - s1_valid, res_valid, res_hit, res_idx, res_tag
  - all valid and found bits, found_count
  - all_found
- Stored hashes are don't-care after reset.
- Reset mid-stream discards in-flight candidates; no result is emitted for them.
- A load at edge k is visible to a compare evaluated at edge k+1 or later. A compare at edge k sees the pre-load contents.

## Test plan
- Reset, then load entries 0..63 with hash = {4{i[31:0]}}. Send cand_hash={4{32'd37}}, tag=5. Expect res_valid 2 cycles later, hit=1, idx=37, tag=5, found_count=1.
- Load entries 3 and 9 with the same hash H; send H twice with mask_found=0, then once with mask_found=1.
  - First two results: idx=3; found_count goes 0→1→1.
  - Third result: idx=9, found_count=2.
- Miss: send a hash present in no entry → hit=0, idx=0, tag echoed, found_count unchanged.
- Back-pressure: stream 4 candidates with res_ready low for 3 cycles.
  - cand_ready drops after 2 accepts and res_* stay stable.
  - All 4 results come out in order with correct tags; none is lost or duplicated.
- Single target loaded: hit it and check all_found=1. Then reload the same index: found clears, found_count=0, all_found=0. Then assert clear_all with a candidate in flight: the result is a miss and all_found=0.
- Assert n_rst asynchronously with a full pipeline and res_ready=0: all outputs are 0 immediately. After release, the first result appears only for a newly accepted candidate.

Source files
------------

// File: rtl/hash_match_bank.sv
// hash_match_bank
// Loadable bank of DEPTH target hashes compared in parallel against a stream
// of candidate hashes. The pipeline has two registers: stage 1 holds the
// accepted candidate and the output register holds the compare result.
// Per-entry found bits record cracked targets. They can mask those entries
// out of later compares, and a counter tracks how many are set.
module hash_match_bank #(
    parameter int HASH_W = 128,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int TAG_W  = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [HASH_W-1:0] load_hash,
    input  logic              clear_all,
    input  logic              mask_found,
    input  logic              cand_valid,
    output logic              cand_ready,
    input  logic [HASH_W-1:0] cand_hash,
    input  logic [TAG_W-1:0]  cand_tag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_hit,
    output logic [IDX_W-1:0]  res_idx,
    output logic [TAG_W-1:0]  res_tag,
    output logic [CNT_W-1:0]  found_count,
    output logic              all_found
);

    // DEPTH widened by one bit so that a load index can be range-checked
    // even when DEPTH is a power of two.
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    // Bank storage
    logic [HASH_W-1:0] r_hash [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_found;
    logic [CNT_W-1:0]  r_found_count;

    // Stage 1
    logic              r_s1_valid;
    logic [HASH_W-1:0] r_s1_hash;
    logic [TAG_W-1:0]  r_s1_tag;

    // Output register
    logic              r_res_valid;
    logic              r_res_hit;
    logic [IDX_W-1:0]  r_res_idx;
    logic [TAG_W-1:0]  r_res_tag;

    // Combinational helpers
    logic              w_advance;
    logic              w_accept;
    logic              w_fire;
    logic              w_load_ok;
    logic [DEPTH-1:0]  w_match;
    logic              w_any_hit;
    logic [IDX_W-1:0]  w_hit_idx;
    logic [DEPTH-1:0]  w_valid_next;
    logic [DEPTH-1:0]  w_found_next;
    logic              w_inc;
    logic              w_dec;
    logic [CNT_W-1:0]  w_count_next;

    assign w_advance  = !r_res_valid || res_ready;
    assign cand_ready = !r_s1_valid || w_advance;
    assign w_accept   = cand_valid && cand_ready;
    assign w_fire     = r_s1_valid && w_advance;
    assign w_load_ok  = load_en && ({1'b0, load_idx} < DEPTH_L);

    // Parallel compare of the stage-1 hash against every eligible entry
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i] && !(mask_found && r_found[i]) &&
                         (r_hash[i] == r_s1_hash);
        end
    end

    // Fixed-priority encoder: the lowest matching index wins, 0 on miss
    always_comb begin
        w_any_hit = |w_match;
        w_hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_hit_idx = w_match[i] ? IDX_W'(i) : w_hit_idx;
        end
    end

    // Next valid/found state and counter. clear_all overrides everything, and
    // a load overrides a same-index hit.
    always_comb begin
        w_valid_next = r_valid;
        w_found_next = r_found;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        if (clear_all) begin
            w_valid_next = '0;
            w_found_next = '0;
        end else begin
            if (w_fire && w_any_hit && !r_found[w_hit_idx]) begin
                w_found_next[w_hit_idx] = 1'b1;
                w_inc                   = 1'b1;
            end else begin
                w_inc = 1'b0;
            end
            if (w_load_ok) begin
                w_valid_next[load_idx] = 1'b1;
                w_found_next[load_idx] = 1'b0;
                w_dec                  = r_found[load_idx];
                if (w_inc && (w_hit_idx == load_idx)) begin
                    w_inc = 1'b0;
                end else begin
                    w_inc = w_inc;
                end
            end else begin
                w_dec = 1'b0;
            end
        end
        w_count_next = clear_all ? {CNT_W{1'b0}}
                                 : (r_found_count + CNT_W'(w_inc) - CNT_W'(w_dec));
    end

    // Hash storage: not reset, because the contents are meaningless until valid is set
    always_ff @(posedge clk) begin
        if (w_load_ok && !clear_all) begin
            r_hash[load_idx] <= load_hash;
        end else begin
            r_hash[load_idx] <= r_hash[load_idx];
        end
    end

    // Valid/found bits and found counter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid       <= '0;
            r_found       <= '0;
            r_found_count <= '0;
        end else begin
            r_valid       <= w_valid_next;
            r_found       <= w_found_next;
            r_found_count <= w_count_next;
        end
    end

    // Stage 1: take a new candidate, otherwise empty once its contents move forward
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_hash  <= '0;
            r_s1_tag   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_hash  <= cand_hash;
            r_s1_tag   <= cand_tag;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Output register: loads the compare result and holds it while the consumer stalls
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_idx   <= '0;
            r_res_tag   <= '0;
        end else if (w_advance) begin
            r_res_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res_hit <= w_any_hit;
                r_res_idx <= w_hit_idx;
                r_res_tag <= r_s1_tag;
            end else begin
                r_res_hit <= r_res_hit;
                r_res_idx <= r_res_idx;
                r_res_tag <= r_res_tag;
            end
        end else begin
            r_res_valid <= r_res_valid;
        end
    end

    assign res_valid   = r_res_valid;
    assign res_hit     = r_res_hit;
    assign res_idx     = r_res_idx;
    assign res_tag     = r_res_tag;
    assign found_count = r_found_count;
    assign all_found   = (|r_valid) && ((r_valid & ~r_found) == {DEPTH{1'b0}});

endmodule

// File: tb/tb_hash_match_bank.sv
// Directed testbench for hash_match_bank with hand-computed expected values.
`timescale 1ns/1ps
module tb_hash_match_bank;

    localparam int HASH_W = 128;
    localparam int DEPTH  = 64;
    localparam int IDX_W  = 6;
    localparam int TAG_W  = 32;
    localparam int CNT_W  = 7;

    logic              clk;
    logic              n_rst;
    logic              load_en;
    logic [IDX_W-1:0]  load_idx;
    logic [HASH_W-1:0] load_hash;
    logic              clear_all;
    logic              mask_found;
    logic              cand_valid;
    logic              cand_ready;
    logic [HASH_W-1:0] cand_hash;
    logic [TAG_W-1:0]  cand_tag;
    logic              res_valid;
    logic              res_ready;
    logic              res_hit;
    logic [IDX_W-1:0]  res_idx;
    logic [TAG_W-1:0]  res_tag;
    logic [CNT_W-1:0]  found_count;
    logic              all_found;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [HASH_W-1:0] H_DUP  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [HASH_W-1:0] H_MISS = 128'h00000000_00000000_00000000_00001234;
    localparam logic [HASH_W-1:0] H_ONE  = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;

    hash_match_bank #(
        .HASH_W(HASH_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .load_en(load_en), .load_idx(load_idx), .load_hash(load_hash),
        .clear_all(clear_all), .mask_found(mask_found),
        .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_hash(cand_hash), .cand_tag(cand_tag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hit(res_hit), .res_idx(res_idx), .res_tag(res_tag),
        .found_count(found_count), .all_found(all_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [31:0] v, input logic [31:0] h,
                             input logic [31:0] idx, input logic [31:0] t);
        check_eq({tag, ".valid"}, 32'(res_valid), v);
        check_eq({tag, ".hit"},   32'(res_hit),   h);
        check_eq({tag, ".idx"},   32'(res_idx),   idx);
        check_eq({tag, ".tag"},   res_tag,        t);
    endtask

    task automatic load_one(input logic [IDX_W-1:0] idx, input logic [HASH_W-1:0] h);
        load_en   = 1'b1;
        load_idx  = idx;
        load_hash = h;
        step();
        load_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        n_rst      = 1'b0;
        load_en    = 1'b0;
        load_idx   = '0;
        load_hash  = '0;
        clear_all  = 1'b0;
        mask_found = 1'b0;
        cand_valid = 1'b0;
        cand_hash  = '0;
        cand_tag   = '0;
        res_ready  = 1'b1;

        // Reset state
        step();
        check_res("rst", 32'd0, 32'd0, 32'd0, 32'd0);
        check_eq("rst.count", 32'(found_count), 32'd0);
        check_eq("rst.all_found", 32'(all_found), 32'd0);
        check_eq("rst.cand_ready", 32'(cand_ready), 32'd1);
        n_rst = 1'b1;
        step();

        // Load entries 0..63 with {4{i}}, then look up entry 37
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'(i);
            load_one(IDX_W'(i), {4{w}});
        end
        w = 32'd37;
        cand_valid = 1'b1;
        cand_hash  = {4{w}};
        cand_tag   = 32'd5;
        step();
        cand_valid = 1'b0;
        check_eq("lat.not_yet", 32'(res_valid), 32'd0);
        step();
        check_res("hit37", 32'd1, 32'd1, 32'd37, 32'd5);
        check_eq("hit37.count", 32'(found_count), 32'd1);
        step();
        check_eq("hit37.drain", 32'(res_valid), 32'd0);

        // Duplicate hash in entries 3 and 9, then mask the found one
        do_clear();
        check_eq("clr.count", 32'(found_count), 32'd0);
        load_one(6'd3, H_DUP);
        load_one(6'd9, H_DUP);
        cand_valid = 1'b1; cand_hash = H_DUP; cand_tag = 32'd11;
        step();
        cand_tag = 32'd12;
        step();
        check_res("dup1", 32'd1, 32'd1, 32'd3, 32'd11);
        check_eq("dup1.count", 32'(found_count), 32'd1);
        cand_tag = 32'd13;
        step();
        check_res("dup2", 32'd1, 32'd1, 32'd3, 32'd12);
        check_eq("dup2.count", 32'(found_count), 32'd1);
        cand_valid = 1'b0;
        mask_found = 1'b1;
        step();
        check_res("dup3", 32'd1, 32'd1, 32'd9, 32'd13);
        check_eq("dup3.count", 32'(found_count), 32'd2);
        mask_found = 1'b0;
        step();

        // Miss
        cand_valid = 1'b1; cand_hash = H_MISS; cand_tag = 32'd77;
        step();
        cand_valid = 1'b0;
        step();
        check_res("miss", 32'd1, 32'd0, 32'd0, 32'd77);
        check_eq("miss.count", 32'(found_count), 32'd2);
        step();

        // Back-pressure: four candidates, consumer stalled for three cycles
        res_ready  = 1'b0;
        cand_valid = 1'b1; cand_hash = H_DUP; cand_tag = 32'd100;
        step();
        check_eq("bp.ready1", 32'(cand_ready), 32'd1);
        cand_hash = H_MISS; cand_tag = 32'd101;
        step();
        cand_hash = H_DUP; cand_tag = 32'd102;
        for (int s = 0; s < 3; s++) begin
            check_eq("bp.stall_ready", 32'(cand_ready), 32'd0);
            check_res("bp.stall", 32'd1, 32'd1, 32'd3, 32'd100);
            step();
        end
        res_ready = 1'b1;
        #1;
        check_eq("bp.resume_ready", 32'(cand_ready), 32'd1);
        check_res("bp.r100", 32'd1, 32'd1, 32'd3, 32'd100);
        step();
        cand_hash = H_MISS; cand_tag = 32'd103;
        check_res("bp.r101", 32'd1, 32'd0, 32'd0, 32'd101);
        step();
        cand_valid = 1'b0;
        check_res("bp.r102", 32'd1, 32'd1, 32'd3, 32'd102);
        step();
        check_res("bp.r103", 32'd1, 32'd0, 32'd0, 32'd103);
        check_eq("bp.count", 32'(found_count), 32'd2);
        step();
        check_eq("bp.drain", 32'(res_valid), 32'd0);

        // Single target: hit, reload, then clear with a candidate in flight
        do_clear();
        load_one(6'd5, H_ONE);
        check_eq("one.all_found0", 32'(all_found), 32'd0);
        cand_valid = 1'b1; cand_hash = H_ONE; cand_tag = 32'd200;
        step();
        cand_valid = 1'b0;
        step();
        check_res("one.hit", 32'd1, 32'd1, 32'd5, 32'd200);
        check_eq("one.count", 32'(found_count), 32'd1);
        check_eq("one.all_found1", 32'(all_found), 32'd1);
        load_one(6'd5, H_ONE);
        check_eq("reload.count", 32'(found_count), 32'd0);
        check_eq("reload.all_found", 32'(all_found), 32'd0);
        cand_valid = 1'b1; cand_hash = H_ONE; cand_tag = 32'd201;
        clear_all  = 1'b1;
        step();
        cand_valid = 1'b0;
        clear_all  = 1'b0;
        step();
        check_res("clr.inflight", 32'd1, 32'd0, 32'd0, 32'd201);
        check_eq("clr.all_found", 32'(all_found), 32'd0);
        check_eq("clr.count2", 32'(found_count), 32'd0);
        step();

        // Asynchronous reset with a full pipeline and the consumer stalled
        load_one(6'd5, H_ONE);
        res_ready  = 1'b0;
        cand_valid = 1'b1; cand_hash = H_ONE; cand_tag = 32'd300;
        step();
        cand_tag = 32'd301;
        step();
        check_eq("ar.pre_valid", 32'(res_valid), 32'd1);
        check_eq("ar.pre_ready", 32'(cand_ready), 32'd0);
        check_eq("ar.pre_count", 32'(found_count), 32'd1);
        #2;
        n_rst      = 1'b0;
        cand_valid = 1'b0;
        #1;
        check_res("ar.now", 32'd0, 32'd0, 32'd0, 32'd0);
        check_eq("ar.count", 32'(found_count), 32'd0);
        check_eq("ar.all_found", 32'(all_found), 32'd0);
        check_eq("ar.cand_ready", 32'(cand_ready), 32'd1);
        step();
        #2;
        n_rst     = 1'b1;
        res_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            check_eq("ar.no_ghost", 32'(res_valid), 32'd0);
        end
        cand_valid = 1'b1; cand_hash = H_ONE; cand_tag = 32'd400;
        step();
        cand_valid = 1'b0;
        step();
        check_res("ar.first", 32'd1, 32'd0, 32'd0, 32'd400);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
